// File: rtl/led_pkg.sv
// Shared definitions for the led_breathe brightness engine: channel mode encodings
// and the channel-select width helper.
package led_pkg;

  typedef enum logic [1:0] {
    LED_MODE_OFF     = 2'd0,
    LED_MODE_SOLID   = 2'd1,
    LED_MODE_BREATHE = 2'd2,
    LED_MODE_BLINK   = 2'd3
  } led_mode_t;

  // A single-channel build still needs a one-bit select field.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_breathe_if.sv
// Configuration write bus for led_breathe: one-cycle write strobe carrying channel,
// register select and data.
interface led_breathe_if
  import led_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8
) ();

  localparam int CHAN_W = chan_w(CHANNELS);

  logic                cfg_we;
  logic [CHAN_W-1:0]   cfg_chan;
  logic                cfg_sel;
  logic [PWM_BITS-1:0] cfg_data;

  modport master (
    output cfg_we,
    output cfg_chan,
    output cfg_sel,
    output cfg_data
  );

  modport slave (
    input cfg_we,
    input cfg_chan,
    input cfg_sel,
    input cfg_data
  );

endinterface

// File: rtl/led_channel.sv
// One LED lane: mode/level registers, phase accumulator, target select and PWM compare.
// Defining LED_BREATHE_GAMMA_EN adds a registered square-law stage ahead of the duty load.
module led_channel
  import led_pkg::*;
#(
  parameter int                PWM_BITS   = 8,
  parameter logic [PWM_BITS:0] PHASE_INIT = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                we_mode,
  input  logic                we_level,
  input  logic [PWM_BITS-1:0] wdata,
  output logic                led_n
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  led_mode_t           mode;
  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS:0]   phase;
  logic [PWM_BITS-1:0] tri_val;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty_src;
  logic [PWM_BITS-1:0] duty_q;
  logic                pwm_wrap;

  assign pwm_wrap = &pwm_cnt;

  // Phase keeps running through mode changes so channels stay in their relative offsets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode  <= LED_MODE_BREATHE;
      level <= MAX;
      phase <= PHASE_INIT;
    end else begin
      if (we_mode)  mode  <= led_mode_t'(wdata[1:0]);
      if (we_level) level <= wdata;
      if (tick)     phase <= phase + (PWM_BITS+1)'(1);
    end
  end

  assign tri_val = phase[PWM_BITS] ? (MAX - phase[PWM_BITS-1:0]) : phase[PWM_BITS-1:0];

  always_comb begin
    target = '0;
    case (mode)
      LED_MODE_OFF:     target = '0;
      LED_MODE_SOLID:   target = level;
      LED_MODE_BREATHE: target = tri_val;
      LED_MODE_BLINK:   target = phase[PWM_BITS] ? '0 : level;
      default:          target = '0;
    endcase
  end

`ifdef LED_BREATHE_GAMMA_EN
  function automatic logic [PWM_BITS-1:0] gamma_sq(input logic [PWM_BITS-1:0] x);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, x} * {{PWM_BITS{1'b0}}, x};
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction

  logic [PWM_BITS-1:0] gamma_p0;

  // ---- stage p0: gamma-corrected target ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) gamma_p0 <= '0;
    else       gamma_p0 <= gamma_sq(target);
  end

  assign duty_src = gamma_p0;
`else
  assign duty_src = target;
`endif

  // ---- duty load on PWM wrap, then registered pin drive ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q <= '0;
      led_n  <= 1'b1;
    end else begin
      if (pwm_wrap) duty_q <= duty_src;
      led_n <= ~(pwm_cnt < duty_q);
    end
  end

endmodule

// File: rtl/led_breathe.sv
// Multi-channel LED breathing engine: shared prescaler and PWM counter, write decode,
// and one led_channel per LED. Optional gamma stage: define LED_BREATHE_GAMMA_EN.
module led_breathe
  import led_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 20
) (
  input  logic                clk,
  input  logic                reset,
  led_breathe_if.slave        cfg,
  output logic [CHANNELS-1:0] led_n
);

  localparam int CHAN_W = chan_w(CHANNELS);

  logic [PRESCALE_BITS-1:0] presc;
  logic [PWM_BITS-1:0]      pwm_cnt;
  logic                     tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= presc + PRESCALE_BITS'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  assign tick = &presc;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    // Evenly spread start phases; two channels land in antiphase.
    localparam logic [PWM_BITS:0] PH = (PWM_BITS+1)'((i * (2 ** (PWM_BITS+1))) / CHANNELS);

    logic hit;
    // Out-of-range channel numbers match no lane and are dropped.
    assign hit = cfg.cfg_we && (cfg.cfg_chan == CHAN_W'(i));

    led_channel #(
      .PWM_BITS   (PWM_BITS),
      .PHASE_INIT (PH)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .pwm_cnt  (pwm_cnt),
      .we_mode  (hit && !cfg.cfg_sel),
      .we_level (hit && cfg.cfg_sel),
      .wdata    (cfg.cfg_data),
      .led_n    (led_n[i])
    );
  end

endmodule
